eth_tx_mac10: RTL and testbench

//  Parametrised 10BASE-T transmit MAC/PHY for the iCE40 Ethernet path; successor to the fixed-frame eth_tx2.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_crc32_byte.sv | 18 +
 rtl/eth_tx_mac10.sv | 247 ++++++++++++++++++++++++
 tb/tb_eth_tx_mac10.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10BASE-T transmit path.
// Holds the FSM state encoding, framing bytes and CRC-32 constants.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        FCS,
        TPIDL,
        IFG
    } eth_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    // FCS goes out as the complemented CRC register, least significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        return ~crc[8 * idx +: 8];
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational byte-wise update of the reflected Ethernet CRC-32.
// Bits are folded in LSB first, matching the on-wire bit order.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_R) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/eth_tx_mac10.sv
// 10BASE-T transmit MAC/PHY: preamble/SFD insertion, optional FCS, Manchester
// line coding, TP_IDL, inter-frame gap and idle-time normal link pulses.
module eth_tx_mac10
    import eth_pkg::*;
#(
    parameter int HALF_BIT_DIV   = 2,
    parameter int PREAMBLE_BYTES = 7,
    parameter bit APPEND_FCS     = 1'b1,
    parameter int TPIDL_HB       = 6,
    parameter int IFG_HB         = 192,
    parameter int NLP_PERIOD_HB  = 320000,
    parameter int NLP_WIDTH_HB   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_p,
    output logic       tx_n,
    output logic       busy,
    output logic       nlp_active,
    output logic       err_underrun
);

    localparam int DIV_W   = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
    localparam int NLP_W   = $clog2(NLP_PERIOD_HB + 1);
    localparam int GAP_MAX = (IFG_HB > TPIDL_HB) ? IFG_HB : TPIDL_HB;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int NLPW_W  = (NLP_WIDTH_HB > 1) ? $clog2(NLP_WIDTH_HB) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(HALF_BIT_DIV - 1);
    localparam logic [NLP_W-1:0]  NLP_LAST   = NLP_W'(NLP_PERIOD_HB - 1);
    localparam logic [NLPW_W-1:0] NLPW_LAST  = NLPW_W'(NLP_WIDTH_HB - 1);
    localparam logic [GAP_W-1:0]  TPIDL_LAST = GAP_W'(TPIDL_HB - 1);
    localparam logic [GAP_W-1:0]  IFG_LAST   = GAP_W'(IFG_HB - 1);
    localparam logic [3:0]        PRE_LAST   = 4'(PREAMBLE_BYTES - 1);

    eth_state_e        state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [3:0]        hb_idx_reg, hb_idx_next;
    logic [3:0]        byte_cnt_reg, byte_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic              last_reg, last_next;
    logic [31:0]       crc_reg, crc_next, crc_upd;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [NLP_W-1:0]  nlp_cnt_reg, nlp_cnt_next;
    logic [NLPW_W-1:0] nlp_left_reg, nlp_left_next;
    logic              nlp_on_reg, nlp_on_next;
    logic              tx_p_reg, tx_p_next;
    logic              tx_n_reg, tx_n_next;

    logic hb_en;
    logic byte_end;
    logic load_req;
    logic consume;
    logic underrun;
    logic bit_val;

    assign hb_en    = (div_cnt_reg == DIV_LAST);
    assign byte_end = (hb_idx_reg == 4'd15);

    eth_crc32_byte u_crc (
        .crc_in  (crc_reg),
        .data    (s_data),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_next    = state_reg;
        hb_idx_next   = hb_idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        last_next     = last_reg;
        crc_next      = crc_reg;
        gap_cnt_next  = gap_cnt_reg;
        nlp_cnt_next  = nlp_cnt_reg;
        nlp_left_next = nlp_left_reg;
        nlp_on_next   = nlp_on_reg;
        load_req      = 1'b0;
        consume       = 1'b0;
        underrun      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (s_valid && !nlp_on_reg) begin
                    state_next    = PRE;
                    hb_idx_next   = 4'd0;
                    byte_cnt_next = 4'd0;
                    shift_next    = PREAMBLE_BYTE;
                    crc_next      = CRC32_INIT;
                    nlp_cnt_next  = '0;
                end else begin
                    if (nlp_on_reg) begin
                        if (nlp_left_reg == '0) begin
                            nlp_on_next = 1'b0;
                        end else begin
                            nlp_left_next = nlp_left_reg - NLPW_W'(1);
                        end
                    end
                    if (nlp_cnt_reg == NLP_LAST) begin
                        nlp_cnt_next  = '0;
                        nlp_on_next   = 1'b1;
                        nlp_left_next = NLPW_LAST;
                    end else begin
                        nlp_cnt_next = nlp_cnt_reg + NLP_W'(1);
                    end
                end
            end
            PRE: begin
                hb_idx_next = hb_idx_reg + 4'd1;
                if (byte_end) begin
                    if (byte_cnt_reg < PRE_LAST) begin
                        byte_cnt_next = byte_cnt_reg + 4'd1;
                        shift_next    = PREAMBLE_BYTE;
                    end else if (byte_cnt_reg == PRE_LAST) begin
                        byte_cnt_next = byte_cnt_reg + 4'd1;
                        shift_next    = SFD_BYTE;
                    end else begin
                        load_req = 1'b1;
                    end
                end
            end
            DATA: begin
                hb_idx_next = hb_idx_reg + 4'd1;
                if (byte_end) begin
                    if (!last_reg) begin
                        load_req = 1'b1;
                    end else if (APPEND_FCS) begin
                        state_next    = FCS;
                        byte_cnt_next = 4'd0;
                        shift_next    = fcs_byte(crc_reg, 2'd0);
                    end else begin
                        state_next   = TPIDL;
                        gap_cnt_next = '0;
                    end
                end
            end
            FCS: begin
                hb_idx_next = hb_idx_reg + 4'd1;
                if (byte_end) begin
                    if (byte_cnt_reg == 4'd3) begin
                        state_next   = TPIDL;
                        gap_cnt_next = '0;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 4'd1;
                        shift_next    = fcs_byte(crc_reg, byte_cnt_reg[1:0] + 2'd1);
                    end
                end
            end
            TPIDL: begin
                if (gap_cnt_reg == TPIDL_LAST) begin
                    state_next   = IFG;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            IFG: begin
                if (gap_cnt_reg == IFG_LAST) begin
                    state_next   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A missing byte at a load point ends the frame without FCS.
        if (load_req) begin
            if (s_valid) begin
                consume    = 1'b1;
                state_next = DATA;
                shift_next = s_data;
                last_next  = s_last;
                crc_next   = crc_upd;
            end else begin
                underrun     = 1'b1;
                state_next   = TPIDL;
                gap_cnt_next = '0;
            end
        end

        // Line level for the half-bit that starts at this hb_en.
        bit_val   = shift_next[hb_idx_next[3:1]];
        tx_p_next = 1'b0;
        tx_n_next = 1'b0;
        case (state_next)
            PRE, DATA, FCS: begin
                tx_p_next = hb_idx_next[0] ? bit_val : ~bit_val;
                tx_n_next = ~tx_p_next;
            end
            TPIDL: tx_p_next = 1'b1;
            IDLE:  tx_p_next = nlp_on_next;
            default: begin
                tx_p_next = 1'b0;
                tx_n_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            hb_idx_reg   <= 4'd0;
            byte_cnt_reg <= 4'd0;
            shift_reg    <= 8'h00;
            last_reg     <= 1'b0;
            crc_reg      <= CRC32_INIT;
            gap_cnt_reg  <= '0;
            nlp_cnt_reg  <= '0;
            nlp_left_reg <= '0;
            nlp_on_reg   <= 1'b0;
            tx_p_reg     <= 1'b0;
            tx_n_reg     <= 1'b0;
        end else begin
            div_cnt_reg <= hb_en ? '0 : div_cnt_reg + DIV_W'(1);
            if (hb_en) begin
                state_reg    <= state_next;
                hb_idx_reg   <= hb_idx_next;
                byte_cnt_reg <= byte_cnt_next;
                shift_reg    <= shift_next;
                last_reg     <= last_next;
                crc_reg      <= crc_next;
                gap_cnt_reg  <= gap_cnt_next;
                nlp_cnt_reg  <= nlp_cnt_next;
                nlp_left_reg <= nlp_left_next;
                nlp_on_reg   <= nlp_on_next;
                tx_p_reg     <= tx_p_next;
                tx_n_reg     <= tx_n_next;
            end
        end
    end

    assign tx_p         = tx_p_reg;
    assign tx_n         = tx_n_reg;
    assign busy         = (state_reg != IDLE);
    assign nlp_active   = nlp_on_reg;
    assign s_ready      = rstn & hb_en & consume;
    assign err_underrun = rstn & hb_en & underrun;

endmodule

// File: tb/tb_eth_tx_mac10.sv
// Scoreboard bench for eth_tx_mac10: a line decoder pops expected bytes pushed
// by the stimulus, and idle-line monitors time the link pulses.
module tb_eth_tx_mac10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready, tx_p, tx_n, busy, nlp_active, err_underrun;

    eth_tx_mac10 #(
        .HALF_BIT_DIV   (2),
        .PREAMBLE_BYTES (7),
        .APPEND_FCS     (1'b1),
        .TPIDL_HB       (6),
        .IFG_HB         (192),
        .NLP_PERIOD_HB  (100),
        .NLP_WIDTH_HB   (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .tx_p         (tx_p),
        .tx_n         (tx_n),
        .busy         (busy),
        .nlp_active   (nlp_active),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] tx_bytes[$];
    logic [7:0] exp_q[$];
    int         exp_len_q[$];

    int frame_done     = 0;
    int frame_start_cyc = 0;
    int tpidl_end_cyc  = 0;
    int last_gap       = 0;
    int line_viol      = 0;
    int idle_viol      = 0;
    int sready_cnt     = 0;
    int err_cnt        = 0;
    int nlp_count      = 0;
    int nlp_rise_cyc   = 0;
    int nlp_prev_rise  = 0;
    int nlp_last_w     = 0;
    int reset_cyc      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rstn === 1'b1) begin
            if (s_ready === 1'b1) sready_cnt++;
            if (err_underrun === 1'b1) err_cnt++;
        end
    end

    // Idle-line monitor: link pulses only, tx_n never driven.
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1 || busy !== 1'b0) begin
                run = 0;
            end else begin
                if (tx_n !== 1'b0 || tx_p !== nlp_active) idle_viol++;
                if (tx_p === 1'b1) begin
                    if (run == 0) begin
                        nlp_prev_rise = nlp_rise_cyc;
                        nlp_rise_cyc  = cyc;
                        nlp_count++;
                    end
                    run++;
                end else if (run != 0) begin
                    nlp_last_w = run;
                    run = 0;
                end
            end
        end
    end

    // Decode one frame starting at the negedge where busy first reads high.
    task automatic decode_frame();
        logic       a, b;
        logic [7:0] sh = 8'h00;
        logic [7:0] e;
        int nbits = 0, nbytes = 0, tp_clk, ifg_clk;
        forever begin
            if (busy !== 1'b1) return;
            a = tx_p;
            if (tx_n !== ~a) line_viol++;
            repeat (2) @(negedge clk);
            if (busy !== 1'b1) return;
            b = tx_p;
            if (tx_n !== ~b) line_viol++;
            if (a == b) break;
            sh = {b, sh[7:1]};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                nbytes++;
                if (exp_q.size() == 0) begin
                    check("line_byte_extra", sh, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("line_byte", sh, e);
                end
            end
            repeat (2) @(negedge clk);
        end
        check("partial_bits", nbits, 0);
        check("tpidl_level", a, 1);
        tp_clk = 3;
        @(negedge clk);
        while (tx_p === 1'b1 && busy === 1'b1 && tp_clk < 64) begin
            tp_clk++;
            @(negedge clk);
        end
        check("tpidl_clk", tp_clk, 12);
        tpidl_end_cyc = cyc;
        ifg_clk = 0;
        while (busy === 1'b1 && ifg_clk < 2000) begin
            if (tx_p !== 1'b0 || tx_n !== 1'b0) line_viol++;
            ifg_clk++;
            @(negedge clk);
        end
        check("ifg_clk", ifg_clk, 384);
        if (exp_len_q.size() == 0) check("frame_len_extra", nbytes, -1);
        else check("frame_len", nbytes, exp_len_q.pop_front());
        frame_done++;
        $display("frame %0d: %0d bytes decoded, tp_idl %0d clk, ifg %0d clk", frame_done, nbytes, tp_clk, ifg_clk);
    endtask

    initial begin
        int prev_end = -1000000;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && busy === 1'b1 && prev_busy == 1'b0) begin
                frame_start_cyc = cyc;
                last_gap = frame_start_cyc - prev_end;
                decode_frame();
                prev_end = tpidl_end_cyc;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic push_expect(input int npay, input logic [31:0] fcs, input bit with_fcs);
        logic [31:0] f;
        f = fcs;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < npay; i++) exp_q.push_back(tx_bytes[i]);
        if (with_fcs) for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
        exp_len_q.push_back(8 + npay + (with_fcs ? 4 : 0));
    endtask

    // drop_at / abort_at: consumed-byte count at which s_valid is released.
    task automatic drive_frame(input int n, input int drop_at, input int abort_at);
        int idx = 0;
        int guard = 0;
        s_valid = 1'b1;
        s_data  = tx_bytes[0];
        s_last  = (n == 1);
        while (idx < n && idx != drop_at && idx != abort_at && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < n) begin
                    s_data = tx_bytes[idx];
                    s_last = (idx == n - 1);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("drive_timeout", guard >= 4000, 0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait_timeout", frame_done >= target, 1);
    endtask

    task automatic wait_nlp(input int target, input int budget);
        int n = 0;
        while (nlp_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("nlp_wait_timeout", nlp_count >= target, 1);
    endtask

    initial begin
        int s0, e0, n0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_p", tx_p, 0);
        check("rst_tx_n", tx_n, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_nlp_active", nlp_active, 0);
        check("rst_err_underrun", err_underrun, 0);
        rstn = 1'b1;
        reset_cyc = cyc;

        // Idle link pulses
        wait_nlp(1, 400);
        check("nlp_first_delay", nlp_rise_cyc - reset_cyc, 200);
        wait_nlp(2, 400);
        check("nlp_period", nlp_rise_cyc - nlp_prev_rise, 200);
        repeat (10) @(negedge clk);
        check("nlp_width_clk", nlp_last_w, 4);

        // "123456789" with FCS
        tx_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_expect(9, 32'hCBF43926, 1'b1);
        s0 = sready_cnt;
        e0 = err_cnt;
        drive_frame(9, -1, -1);
        wait_frames(1, 3000);
        check("crc_frame_s_ready", sready_cnt - s0, 9);
        check("crc_frame_err", err_cnt - e0, 0);

        // Underrun at byte 10 of 60
        tx_bytes.delete();
        for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i * 7 + 3));
        push_expect(9, 32'h0, 1'b0);
        s0 = sready_cnt;
        e0 = err_cnt;
        drive_frame(60, 9, -1);
        wait_frames(2, 3000);
        check("underrun_pulses", err_cnt - e0, 1);
        check("underrun_s_ready", sready_cnt - s0, 9);

        // Back-to-back: second frame requested while the first is still on the line
        tx_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_expect(9, 32'hCBF43926, 1'b1);
        drive_frame(9, -1, -1);
        n0 = nlp_count;
        tx_bytes = '{8'h61};
        push_expect(1, 32'hE8B7BE43, 1'b1);
        s0 = sready_cnt;
        drive_frame(1, -1, -1);
        wait_frames(4, 5000);
        check("b2b_gap_ge_384", last_gap >= 384, 1);
        check("b2b_no_nlp", nlp_count - n0, 0);
        check("b2b_s_ready", sready_cnt - s0, 1);

        // Reset in the middle of byte 5
        tx_bytes.delete();
        for (int i = 0; i < 20; i++) tx_bytes.push_back(8'(8'hA0 + i));
        push_expect(20, 32'h0, 1'b0);
        drive_frame(20, -1, 5);
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_tx_p", tx_p, 0);
        check("midrst_tx_n", tx_n, 0);
        check("midrst_busy", busy, 0);
        rstn = 1'b1;
        reset_cyc = cyc;
        exp_q.delete();
        exp_len_q.delete();
        n0 = nlp_count;
        wait_nlp(n0 + 1, 400);
        check("midrst_nlp_delay", nlp_rise_cyc - reset_cyc, 200);
        repeat (10) @(negedge clk);

        check("idle_line_violations", idle_viol, 0);
        check("frame_line_violations", line_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
